mem_port_arbiter: RTL

//  Shares one single-port synchronous word memory between the CPU instruction-fetch

---
 rtl/mem_port_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous word memory between an instruction
// fetch port (I) and a load/store port (D). One access in flight: IDLE -> ISSUE -> RESP.
module mem_port_arbiter #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic [31:0]   d_addr,
  input  logic [3:0]    d_wmask,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_ren,
  output logic [3:0]    mem_wmask,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q;
  logic   last_d_q;   // 1: most recent grant went to D
  logic   owner_d_q;  // 1: access in flight belongs to D
  logic   i_ack_q;
  logic   d_ack_q;
  logic   grant_any;
  logic   grant_d;

  // D wins only if I is idle or I had the previous grant.
  always_comb begin
    grant_any = i_req | d_req;
    grant_d   = d_req & (~i_req | ~last_d_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b1;
      owner_d_q <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      mem_addr  <= '0;
      mem_ren   <= 1'b0;
      mem_wmask <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            owner_d_q <= grant_d;
            last_d_q  <= grant_d;
            if (grant_d) begin
              mem_addr  <= d_addr[AW+1:2];
              mem_ren   <= (d_wmask == 4'b0000);
              mem_wmask <= d_wmask;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= i_addr[AW+1:2];
              mem_ren   <= 1'b1;
              mem_wmask <= 4'b0000;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          mem_ren   <= 1'b0;
          mem_wmask <= 4'b0000;
          i_ack_q   <= ~owner_d_q;
          d_ack_q   <= owner_d_q;
          state_q   <= StResp;
        end
        StResp: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset during RESP suppresses the ack in that same cycle; the access is abandoned.
  always_comb begin
    i_ack   = i_ack_q & ~reset;
    d_ack   = d_ack_q & ~reset;
    i_rdata = i_ack ? mem_rdata : 32'h0;
    d_rdata = d_ack ? mem_rdata : 32'h0;
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

endmodule
